sw_debounce_sync: RTL and testbench

Input-conditioning stage directly upstream of the picomips core. It synchronises the raw board switches SW[9:0] into the clk domain and debounces the two control switches: SW8, the operand/step handshake, and SW9, the program-counter enable. It also produces single-cycle edge pulses and a stable operand byte captured at the SW8 press. Its SW_clean output drives the core's SW port directly.

---
 rtl/sw_debounce_sync.sv | 144 ++++++++++++++
 tb/tb_sw_debounce_sync.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// Switch conditioning ahead of the picomips core: 2-flop synchroniser on SW[9:0],
// debounce FSMs on SW8/SW9, edge pulses and an operand byte captured at the SW8 press.
module sw_debounce_sync #(
   parameter int n        = 8,
   parameter int DB_COUNT = 50000,
   parameter int CNT_W    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    SW_raw,
   output logic [9:0]    SW_clean,
   output logic          sw8_rise,
   output logic          sw8_fall,
   output logic          sw9_rise,
   output logic [n-1:0]  data_latched,
   output logic          data_valid
);

   typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

   logic [9:0]   sync1_q;
   logic [9:0]   sync2_q;
   logic [1:0]   level;
   logic [1:0]   enter_hi;
   logic [1:0]   enter_lo;
   logic [1:0]   rise_q;
   logic         fall8_q;
   logic [n-1:0] data_latched_q, data_latched_d;
   logic         data_valid_q, data_valid_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= SW_raw;
         sync2_q <= sync1_q;
      end
   end

   // Index 0 debounces SW8, index 1 debounces SW9; both read only sync2.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_db
      db_state_t        state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;
      logic             in_s;
      logic             cnt_done;

      assign in_s         = sync2_q[8+gi];
      assign cnt_done     = (cnt_q == CNT_LAST);
      assign enter_hi[gi] = (state_q == WAIT_HI) && in_s && cnt_done;
      assign enter_lo[gi] = (state_q == WAIT_LO) && !in_s && cnt_done;
      assign level[gi]    = level_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
         end else begin
            case (state_q)
               STABLE_LO: begin
                  if (in_s) begin
                     state_q <= WAIT_HI;
                     cnt_q   <= '0;
                  end
               end
               WAIT_HI: begin
                  if (!in_s) begin
                     state_q <= STABLE_LO;
                     cnt_q   <= '0;
                  end else if (enter_hi[gi]) begin
                     state_q <= STABLE_HI;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               STABLE_HI: begin
                  if (!in_s) begin
                     state_q <= WAIT_LO;
                     cnt_q   <= '0;
                  end
               end
               WAIT_LO: begin
                  if (in_s) begin
                     state_q <= STABLE_HI;
                     cnt_q   <= '0;
                  end else if (enter_lo[gi]) begin
                     state_q <= STABLE_LO;
                     cnt_q   <= '0;
                     level_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= STABLE_LO;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Operand is taken from sync2 as it stood before the acceptance edge.
   always_comb begin
      data_latched_d = data_latched_q;
      data_valid_d   = data_valid_q;
      if (enter_hi[0]) begin
         data_latched_d = sync2_q[n-1:0];
         data_valid_d   = 1'b1;
      end else if (enter_lo[0]) begin
         data_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_q         <= '0;
         fall8_q        <= 1'b0;
         data_latched_q <= '0;
         data_valid_q   <= 1'b0;
      end else begin
         rise_q         <= enter_hi;
         fall8_q        <= enter_lo[0];
         data_latched_q <= data_latched_d;
         data_valid_q   <= data_valid_d;
      end
   end

   assign SW_clean     = {level, sync2_q[7:0]};
   assign sw8_rise     = rise_q[0];
   assign sw9_rise     = rise_q[1];
   assign sw8_fall     = fall8_q;
   assign data_latched = data_latched_q;
   assign data_valid   = data_valid_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Scoreboard bench: two builds (DB_COUNT=4 and DB_COUNT=1) share the raw switches and are
// checked every cycle against a run-length reference model of the switch conditioning rules.
module tb_sw_debounce_sync;

   typedef struct packed {
      logic [9:0] clean;
      logic       r8;
      logic       f8;
      logic       r9;
      logic [7:0] lat;
      logic       val;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } pair_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] sw_raw;

   logic [9:0] clean0, clean1;
   logic       r8_0, f8_0, r9_0, val0;
   logic       r8_1, f8_1, r9_1, val1;
   logic [7:0] lat0, lat1;
   obs_t       act0, act1;

   always #5 clk = ~clk;

   sw_debounce_sync #(.n(8), .DB_COUNT(4), .CNT_W(16)) u_dut4 (
      .clk(clk), .reset(reset), .SW_raw(sw_raw), .SW_clean(clean0),
      .sw8_rise(r8_0), .sw8_fall(f8_0), .sw9_rise(r9_0),
      .data_latched(lat0), .data_valid(val0)
   );

   sw_debounce_sync #(.n(8), .DB_COUNT(1), .CNT_W(1)) u_dut1 (
      .clk(clk), .reset(reset), .SW_raw(sw_raw), .SW_clean(clean1),
      .sw8_rise(r8_1), .sw8_fall(f8_1), .sw9_rise(r9_1),
      .data_latched(lat1), .data_valid(val1)
   );

   assign act0 = {clean0, r8_0, f8_0, r9_0, lat0, val0};
   assign act1 = {clean1, r8_1, f8_1, r9_1, lat1, val1};

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   pair_t exp_q[$];

   // Reference model: a switch level is accepted once the synchronised input has shown
   // the same new value on DB_COUNT+1 consecutive sampling edges.
   int         db_of[2] = '{4, 1};
   logic [9:0] hist[$];
   int         run_len[2][2];
   logic       run_val[2][2];
   logic       lvl[2][2];
   logic [7:0] m_lat[2];
   logic       m_val[2];
   obs_t       mexp[2];

   task automatic model_step(input logic rst_now, input logic [9:0] raw_now);
      logic [9:0] s2, s1;
      logic       bitv;
      if (rst_now) begin
         hist = '{10'h0, 10'h0};
         for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 2; b++) begin
               run_len[i][b] = 0;
               run_val[i][b] = 1'b0;
               lvl[i][b]     = 1'b0;
            end
            m_lat[i] = '0;
            m_val[i] = 1'b0;
            mexp[i]  = '0;
         end
      end else begin
         s2 = hist[0];
         s1 = hist[1];
         for (int i = 0; i < 2; i++) begin
            mexp[i] = '0;
            for (int b = 0; b < 2; b++) begin
               bitv = s2[8+b];
               if (run_len[i][b] > 0 && bitv == run_val[i][b]) begin
                  run_len[i][b]++;
               end else begin
                  run_val[i][b] = bitv;
                  run_len[i][b] = 1;
               end
               if (run_val[i][b] != lvl[i][b] && run_len[i][b] >= db_of[i] + 1) begin
                  lvl[i][b] = run_val[i][b];
                  if (b == 0) begin
                     if (lvl[i][b]) begin
                        mexp[i].r8 = 1'b1;
                        m_lat[i]   = s2[7:0];
                        m_val[i]   = 1'b1;
                     end else begin
                        mexp[i].f8 = 1'b1;
                        m_val[i]   = 1'b0;
                     end
                  end else if (lvl[i][b]) begin
                     mexp[i].r9 = 1'b1;
                  end
               end
            end
            mexp[i].clean = {lvl[i][1], lvl[i][0], s1[7:0]};
            mexp[i].lat   = m_lat[i];
            mexp[i].val   = m_val[i];
         end
         void'(hist.pop_front());
         hist.push_back(raw_now);
      end
   endtask

   task automatic check(input string nm, input obs_t act, input obs_t want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         pair_t e;
         e = exp_q.pop_front();
         check("db4", act0, e.a);
         check("db1", act1, e.b);
         if (e.a.r8 | e.a.f8 | e.a.r9)
            $display("txn cyc=%0d db4 clean=%h rise8=%b fall8=%b rise9=%b latched=%h valid=%b",
                     cyc, clean0, r8_0, f8_0, r9_0, lat0, val0);
         if (e.b.r8 | e.b.f8 | e.b.r9)
            $display("txn cyc=%0d db1 clean=%h rise8=%b fall8=%b rise9=%b latched=%h valid=%b",
                     cyc, clean1, r8_1, f8_1, r9_1, lat1, val1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_step(reset, sw_raw);
      exp_q.push_back({mexp[0], mexp[1]});
   endtask

   task automatic hold(input logic [9:0] v, input int ncyc);
      sw_raw = v;
      repeat (ncyc) tick();
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Assert reset between edges and confirm every output clears without a clock edge.
   task automatic pulse_reset(input int ncyc);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_db4", act0, '0);
      check("async_rst_db1", act1, '0);
      repeat (ncyc) tick();
      release_reset();
   endtask

   // Raw pulse that starts and ends between two sampling edges.
   task automatic glitch();
      #2;
      sw_raw[9:8] = 2'b11;
      #2;
      sw_raw[9:8] = 2'b00;
   endtask

   initial begin
      logic [9:0] v;
      int         seg;
      reset  = 1'b1;
      sw_raw = '0;
      repeat (2) tick();
      release_reset();
      hold(10'h000, 4);

      sw_raw = 10'h3FF;
      pulse_reset(3);
      hold(10'h3FF, 10);
      hold(10'h000, 10);

      hold({2'b01, 8'hA5}, 10);
      hold({2'b01, 8'h3C}, 4);
      hold({2'b00, 8'h3C}, 10);

      hold({2'b01, 8'hA5}, 3);
      hold({2'b00, 8'hA5}, 1);
      hold({2'b01, 8'hA5}, 10);
      hold({2'b00, 8'hA5}, 10);

      hold({2'b11, 8'hC3}, 10);
      hold({2'b00, 8'hC3}, 10);

      sw_raw = 10'h000;
      repeat (4) begin
         tick();
         glitch();
      end
      hold(10'h100, 2);
      hold(10'h000, 6);
      hold(10'h200, 2);
      hold(10'h000, 6);

      v = 10'h000;
      for (int s = 0; s < 120; s++) begin
         if ($urandom_range(0, 1) == 0) v[8] = ~v[8];
         if ($urandom_range(0, 2) == 0) v[9] = ~v[9];
         if ($urandom_range(0, 3) == 0) v[7:0] = 8'($urandom);
         seg = $urandom_range(1, 8);
         if ($urandom_range(0, 29) == 0) begin
            sw_raw = v;
            pulse_reset($urandom_range(1, 3));
         end
         hold(v, seg);
         if ($urandom_range(0, 9) == 0) glitch();
         if ($urandom_range(0, 9) == 0) hold(v, 1);
      end
      hold(10'h000, 12);

      repeat (3) @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
